// File: rtl/compmult_acc_if.sv
// Sample/result bundle for compmult_acc: operand stream in, scaled frame sums out.
interface compmult_acc_if #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 16,
  parameter int LEN_WIDTH = 8
);
  logic                        ce;
  logic                        clr;
  logic signed [A_WIDTH-1:0]   ar;
  logic signed [A_WIDTH-1:0]   ai;
  logic signed [B_WIDTH-1:0]   br;
  logic signed [B_WIDTH-1:0]   bi;
  logic                        conj_b;
  logic [LEN_WIDTH-1:0]        len;
  logic                        valid_i;
  logic signed [OUT_WIDTH-1:0] pr;
  logic signed [OUT_WIDTH-1:0] pi;
  logic                        valid_o;
  logic                        sat_o;

  modport master (
    output ce, clr, ar, ai, br, bi, conj_b, len, valid_i,
    input  pr, pi, valid_o, sat_o
  );

  modport slave (
    input  ce, clr, ar, ai, br, bi, conj_b, len, valid_i,
    output pr, pi, valid_o, sat_o
  );
endinterface

// File: rtl/compmult_acc.sv
// Complex multiply (optionally by conj(b)) and frame accumulate, with rounded,
// saturated output. Pipeline: S1 regs, S2 products, S3 re/im, S4 acc, S5 scale.
module compmult_acc #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int LEN_WIDTH = 8
) (
  input logic            CLK,
  input logic            RST,
  compmult_acc_if.slave  bus
);
  localparam int PW  = A_WIDTH + B_WIDTH;
  localparam int RW  = ACC_WIDTH + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // vld_pipe[0..2] qualify S1..S3
  logic [2:0] vld_pipe;

  logic signed [A_WIDTH-1:0]   s1_ar, s1_ai;
  logic signed [B_WIDTH-1:0]   s1_br, s1_bi;
  logic                        s1_conj, s2_conj;
  logic signed [PW-1:0]        p_rr, p_ri, p_ir, p_ii;
  logic signed [ACC_WIDTH-1:0] s3_re, s3_im;

  logic [LEN_WIDTH-1:0]        cnt, frame_len, len_eff, flen;
  logic                        first, last, acc_done;
  logic signed [ACC_WIDTH-1:0] acc_r, acc_i;
  logic signed [OUT_WIDTH-1:0] q_r, q_i;
  logic                        sat_r, sat_i;

  // Datapath registers carry no reset; validity lives in vld_pipe.
  always_ff @(posedge CLK) begin
    if (bus.ce) begin
      s1_ar   <= bus.ar;
      s1_ai   <= bus.ai;
      s1_br   <= bus.br;
      s1_bi   <= bus.bi;
      s1_conj <= bus.conj_b;
      p_rr    <= PW'(s1_ar) * PW'(s1_br);
      p_ri    <= PW'(s1_ar) * PW'(s1_bi);
      p_ir    <= PW'(s1_ai) * PW'(s1_br);
      p_ii    <= PW'(s1_ai) * PW'(s1_bi);
      s2_conj <= s1_conj;
      s3_re   <= s2_conj ? ACC_WIDTH'(p_rr) + ACC_WIDTH'(p_ii)
                         : ACC_WIDTH'(p_rr) - ACC_WIDTH'(p_ii);
      s3_im   <= s2_conj ? ACC_WIDTH'(p_ir) - ACC_WIDTH'(p_ri)
                         : ACC_WIDTH'(p_ir) + ACC_WIDTH'(p_ri);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         vld_pipe <= '0;
    else if (bus.ce)  vld_pipe <= bus.clr ? 3'b000 : {vld_pipe[1:0], bus.valid_i};
  end

  // len is looked at only when a frame's first sample lands in S4.
  always_comb begin
    len_eff = (bus.len == '0) ? LEN_WIDTH'(1) : bus.len;
    first   = (cnt == '0);
    flen    = first ? len_eff : frame_len;
    last    = (LEN_WIDTH'(cnt + 1'b1) == flen);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt       <= '0;
      frame_len <= '0;
      acc_r     <= '0;
      acc_i     <= '0;
      acc_done  <= 1'b0;
    end else if (bus.ce) begin
      if (bus.clr) begin
        cnt      <= '0;
        acc_r    <= '0;
        acc_i    <= '0;
        acc_done <= 1'b0;
      end else begin
        acc_done <= 1'b0;
        if (vld_pipe[2]) begin
          acc_r <= first ? s3_re : acc_r + s3_re;
          acc_i <= first ? s3_im : acc_i + s3_im;
          if (first) frame_len <= len_eff;
          if (last) begin
            cnt      <= '0;
            acc_done <= 1'b1;
          end else begin
            cnt <= LEN_WIDTH'(cnt + 1'b1);
          end
        end
      end
    end
  end

  // Round half up, arithmetic shift, clip; one extra bit keeps the rounding add from wrapping.
  function automatic logic [OUT_WIDTH:0] scale(input logic signed [ACC_WIDTH-1:0] s);
    logic signed [RW-1:0] x;
    x = (RW'(s) + RND) >>> SHIFT;
    if (x > MAXV)      scale = {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (x < MINV) scale = {1'b1, MINV[OUT_WIDTH-1:0]};
    else               scale = {1'b0, x[OUT_WIDTH-1:0]};
  endfunction

  always_comb begin
    {sat_r, q_r} = scale(acc_r);
    {sat_i, q_i} = scale(acc_i);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.pr      <= '0;
      bus.pi      <= '0;
      bus.valid_o <= 1'b0;
      bus.sat_o   <= 1'b0;
    end else if (bus.ce) begin
      bus.valid_o <= acc_done;
      if (acc_done) begin
        bus.pr    <= q_r;
        bus.pi    <= q_i;
        bus.sat_o <= sat_r | sat_i;
      end
    end
  end
endmodule

// File: tb/tb_compmult_acc.sv
// Directed bench: dut0 is SHIFT=0/OUT=40, dut1 is SHIFT=15/OUT=16, both fed the same stream.
module tb_compmult_acc;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic              ce, clr, conj_b, valid_i;
  logic signed [15:0] ar, ai, br, bi;
  logic [7:0]        len;

  compmult_acc_if #(.A_WIDTH(16), .B_WIDTH(16), .OUT_WIDTH(40), .LEN_WIDTH(8)) bus0();
  compmult_acc_if #(.A_WIDTH(16), .B_WIDTH(16), .OUT_WIDTH(16), .LEN_WIDTH(8)) bus1();

  assign bus0.ce = ce;      assign bus1.ce = ce;
  assign bus0.clr = clr;    assign bus1.clr = clr;
  assign bus0.ar = ar;      assign bus1.ar = ar;
  assign bus0.ai = ai;      assign bus1.ai = ai;
  assign bus0.br = br;      assign bus1.br = br;
  assign bus0.bi = bi;      assign bus1.bi = bi;
  assign bus0.conj_b = conj_b;  assign bus1.conj_b = conj_b;
  assign bus0.len = len;    assign bus1.len = len;
  assign bus0.valid_i = valid_i;  assign bus1.valid_i = valid_i;

  compmult_acc #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(40),
                 .SHIFT(0), .LEN_WIDTH(8)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  compmult_acc #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(16),
                 .SHIFT(15), .LEN_WIDTH(8)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  typedef struct { longint pr; longint pi; int sat; int stamp; } ev_t;
  ev_t q0[$], q1[$];
  ev_t e0, e1;
  int  cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus0.valid_o) begin
      e0.pr = longint'(bus0.pr); e0.pi = longint'(bus0.pi);
      e0.sat = int'(bus0.sat_o); e0.stamp = cyc;
      q0.push_back(e0);
    end
    if (bus1.valid_o) begin
      e1.pr = longint'(bus1.pr); e1.pi = longint'(bus1.pi);
      e1.sat = int'(bus1.sat_o); e1.stamp = cyc;
      q1.push_back(e1);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic samp(int a_r, int a_i, int b_r, int b_i, int cj, output int k);
    ar = 16'(a_r); ai = 16'(a_i); br = 16'(b_r); bi = 16'(b_i);
    conj_b = cj[0];
    valid_i = 1'b1;
    k = cyc;
    step();
    valid_i = 1'b0;
  endtask

  task automatic flush();
    clr = 1'b1;
    step();
    clr = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic check_count(string nm, int n);
    chk({nm, ".cnt0"}, longint'(q0.size()), longint'(n));
    chk({nm, ".cnt1"}, longint'(q1.size()), longint'(n));
  endtask

  task automatic check_one(string nm, int idx, int stamp,
                           longint e0r, longint e0i, int e0s,
                           longint e1r, longint e1i, int e1s);
    if (idx < q0.size()) begin
      chk({nm, ".pr0"}, q0[idx].pr, e0r);
      chk({nm, ".pi0"}, q0[idx].pi, e0i);
      chk({nm, ".sat0"}, longint'(q0[idx].sat), longint'(e0s));
      if (stamp >= 0) chk({nm, ".lat"}, longint'(q0[idx].stamp), longint'(stamp));
    end
    if (idx < q1.size()) begin
      chk({nm, ".pr1"}, q1[idx].pr, e1r);
      chk({nm, ".pi1"}, q1[idx].pi, e1i);
      chk({nm, ".sat1"}, longint'(q1[idx].sat), longint'(e1s));
    end
  endtask

  typedef struct {
    int ar, ai, br, bi, cj, ln;
    longint p0r, p0i; int s0;
    longint p1r, p1i; int s1;
  } vec_t;
  vec_t tv[8];

  initial begin
    int k, k1;
    ce = 1'b1; clr = 1'b0; conj_b = 1'b0; valid_i = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0; len = 8'd1;

    tv[0] = '{3, 4, 5, -2, 0, 1, 23, 14, 0, 0, 0, 0};
    tv[1] = '{3, 4, 5, -2, 1, 1, 7, 26, 0, 0, 0, 0};
    tv[2] = '{16384, 0, 1, 0, 0, 1, 16384, 0, 0, 1, 0, 0};
    tv[3] = '{32767, 0, 32767, 0, 0, 1, 1073676289, 0, 0, 32766, 0, 0};
    tv[4] = '{-32768, 0, -32768, -32768, 0, 1, 1073741824, 1073741824, 0, 32767, 32767, 1};
    tv[5] = '{-16385, 0, 1, 0, 0, 1, -16385, 0, 0, -1, 0, 0};
    tv[6] = '{-32768, 32767, 32767, 32767, 0, 1, -2147385345, -32767, 0, -32768, -1, 1};
    tv[7] = '{3, 4, 5, -2, 1, 0, 7, 26, 0, 0, 0, 0};

    repeat (3) step();
    chk("rst.pr0", longint'(bus0.pr), 0);
    chk("rst.pi0", longint'(bus0.pi), 0);
    chk("rst.vo0", longint'(bus0.valid_o), 0);
    chk("rst.sat1", longint'(bus1.sat_o), 0);
    RST = 1'b1;
    step();

    // streaming, len=1 (and len=0)
    for (int i = 0; i < 8; i++) begin
      q0.delete(); q1.delete();
      len = 8'(tv[i].ln);
      samp(tv[i].ar, tv[i].ai, tv[i].br, tv[i].bi, tv[i].cj, k);
      repeat (6) step();
      check_count($sformatf("vec%0d", i), 1);
      check_one($sformatf("vec%0d", i), 0, k + 5, tv[i].p0r, tv[i].p0i, tv[i].s0,
                tv[i].p1r, tv[i].p1i, tv[i].s1);
      chk($sformatf("vec%0d.hold0", i), longint'(bus0.pr), tv[i].p0r);
      chk($sformatf("vec%0d.hold1", i), longint'(bus1.pr), tv[i].p1r);
    end

    // 4-sample frame with an idle gap
    flush(); len = 8'd4;
    samp(1, 0, 100, -50, 0, k); samp(1, 0, 100, -50, 0, k);
    step();
    samp(1, 0, 100, -50, 0, k); samp(1, 0, 100, -50, 0, k);
    repeat (8) step();
    check_count("gap", 1);
    check_one("gap", 0, k + 5, 400, -200, 0, 0, 0, 0);

    // saturation over a 2-sample frame
    flush(); len = 8'd2;
    samp(32767, 0, 32767, 0, 0, k); samp(32767, 0, 32767, 0, 0, k);
    repeat (8) step();
    check_count("sat", 1);
    check_one("sat", 0, k + 5, 2147352578, 0, 0, 32767, 0, 1);

    // ce low mid-frame with a junk valid sample that must be ignored
    flush(); len = 8'd4;
    samp(1, 0, 100, -50, 0, k); samp(1, 0, 100, -50, 0, k);
    ce = 1'b0; ar = 16'sd9; ai = 16'sd9; valid_i = 1'b1;
    repeat (3) step();
    ce = 1'b1; valid_i = 1'b0;
    samp(1, 0, 100, -50, 0, k); samp(1, 0, 100, -50, 0, k);
    repeat (8) step();
    check_count("ce_mid", 1);
    check_one("ce_mid", 0, k + 5, 400, -200, 0, 0, 0, 0);

    // ce low right after the only sample: output delayed by 3
    flush(); len = 8'd1;
    samp(3, 4, 5, -2, 0, k);
    ce = 1'b0;
    repeat (3) step();
    ce = 1'b1;
    repeat (8) step();
    check_count("ce_lat", 1);
    check_one("ce_lat", 0, k + 8, 23, 14, 0, 0, 0, 0);

    // clr abort after two accumulated samples, junk sample alongside clr
    flush(); len = 8'd4;
    samp(1, 0, 100, -50, 0, k); samp(1, 0, 100, -50, 0, k);
    repeat (4) step();
    clr = 1'b1; ar = 16'sd7; valid_i = 1'b1;
    step();
    clr = 1'b0; valid_i = 1'b0;
    for (int i = 0; i < 4; i++) samp(2, 0, 10, 20, 0, k);
    repeat (8) step();
    check_count("clr", 1);
    check_one("clr", 0, k + 5, 80, 160, 0, 0, 0, 0);

    // back-to-back len=2 frames
    flush(); len = 8'd2;
    samp(1, 0, 5, 0, 0, k1); samp(1, 0, 5, 0, 0, k1);
    samp(1, 0, 0, 7, 0, k);  samp(1, 0, 0, 7, 0, k);
    repeat (8) step();
    check_count("b2b", 2);
    check_one("b2b.f0", 0, k1 + 5, 10, 0, 0, 0, 0, 0);
    check_one("b2b.f1", 1, k + 5, 0, 14, 0, 0, 0, 0);

    // len changed after the frame's first sample reached the accumulator
    flush(); len = 8'd3;
    samp(1, 0, 3, 0, 0, k); samp(1, 0, 3, 0, 0, k); samp(1, 0, 3, 0, 0, k);
    step();
    len = 8'd1;
    repeat (8) step();
    check_count("lenchg", 1);
    check_one("lenchg", 0, k + 5, 9, 0, 0, 0, 0, 0);

    // async reset mid-frame, away from the clock edge
    len = 8'd4;
    samp(1, 0, 100, -50, 0, k); samp(1, 0, 100, -50, 0, k);
    #3 RST = 1'b0;
    #1;
    chk("arst.pr0", longint'(bus0.pr), 0);
    chk("arst.vo0", longint'(bus0.valid_o), 0);
    #2 RST = 1'b1;
    step();
    q0.delete(); q1.delete();
    for (int i = 0; i < 4; i++) samp(2, 0, 10, 20, 0, k);
    repeat (8) step();
    check_count("arst", 1);
    check_one("arst", 0, k + 5, 80, 160, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/compmult_acc.md
COMPMULT_ACC -- requirements
Module: compmult_acc

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, signed width of operand a (real and imag).
REQ-002 SHALL have parameter B_WIDTH, default 16, signed width of operand b.
REQ-003 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width; must be >= A_WIDTH+B_WIDTH+1.
REQ-004 SHALL have parameter OUT_WIDTH, default 16, signed output width.
REQ-005 SHALL have parameter SHIFT, default 15, right shift from accumulator to output; range 0..ACC_WIDTH-OUT_WIDTH.
REQ-006 SHALL have parameter LEN_WIDTH, default 8, width of the len port.
REQ-007 CLK  in  1  clock; all state updates on rising edge.
REQ-008 RST  in  1  reset, asynchronous, active-low.
REQ-009 ce  in  1  clock enable; low freezes every register, including counters and valid pipeline.
REQ-010 clr  in  1  synchronous frame abort, effective only when ce=1.
REQ-011 ar, ai  in  A_WIDTH  signed operand a.
REQ-012 br, bi  in  B_WIDTH  signed operand b.
REQ-013 conj_b  in  1  1 = multiply by conj(b); sampled with each valid_i.
REQ-014 len  in  LEN_WIDTH  samples per accumulation frame; 0 is treated as 1.
REQ-015 valid_i  in  1  input sample qualifier.
REQ-016 pr, pi  out  OUT_WIDTH  signed rounded and saturated frame sum.
REQ-017 valid_o  out  1  one-cycle strobe marking pr/pi valid.
REQ-018 sat_o  out  1  high with valid_o when pr or pi saturated.

Function
REQ-019 S1 SHALL register ar, ai, br, bi, conj_b and valid_i when ce=1.
REQ-020 S2 SHALL register the four full-width products ar*br, ar*bi, ai*br and ai*bi.
REQ-021 With conj=0, S3 SHALL form re = ar*br - ai*bi and im = ai*br + ar*bi.
REQ-022 With conj=1, S3 SHALL form re = ar*br + ai*bi and im = ai*br - ar*bi.
REQ-023 S3 results SHALL be sign-extended to ACC_WIDTH.
REQ-024 S4 SHALL hold a frame counter cnt and accumulators acc_r/acc_i; the first valid S3 sample of a frame loads acc, later samples add to it.
REQ-025 len SHALL be captured as frame_len when the first sample of a frame enters S4; changing len mid-frame SHALL have no effect on the current frame.
REQ-026 When the sample count in a frame reaches frame_len, S5 SHALL output the completed frame sum, set valid_o=1 for one ce-cycle, and reset cnt to 0.
REQ-027 Output scaling: for SHIFT>0, add 2^(SHIFT-1) to the sum, then shift right arithmetically by SHIFT; for SHIFT=0, output the sum unchanged.
REQ-028 The scaled value SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and sat_o SHALL be set if either component clipped.
REQ-029 Latency: with ce held high, the last frame sample on valid_i at edge t SHALL give valid_o high after edge t+4.
REQ-030 Non-valid cycles inside a frame SHALL not advance cnt or change acc; gaps of any length are allowed.
REQ-031 Accumulator overflow beyond ACC_WIDTH SHALL wrap in two's complement; only the output stage saturates.
REQ-032 clr=1 SHALL zero cnt and acc and clear S1-S3 valid bits; a sample presented with clr is discarded.
REQ-033 valid_o SHALL not assert after clr for any aborted frame.
REQ-034 pr, pi and sat_o SHALL hold their last values between valid_o strobes.
REQ-035 When frame_len=1, every valid sample SHALL produce valid_o, giving a streaming multiplier with scaling.
REQ-036 Back-to-back frames SHALL need no idle cycle: a sample arriving the cycle after a frame's last sample starts the next frame.

Reset
REQ-037 RST low SHALL asynchronously clear all valid bits, cnt, acc_r, acc_i, pr, pi, valid_o and sat_o to 0.
REQ-038 Data registers in S1-S3 SHALL not need reset.
REQ-039 Reset asserted mid-frame SHALL discard the partial frame, and the first valid after release SHALL start a new frame.

Verification
REQ-040 Streaming case: SHIFT=0, OUT_WIDTH=40, len=1, a=(3,4), b=(5,-2), conj_b=0 -> (23,14) four cycles later, sat_o=0; same with conj_b=1 -> (7,26).
REQ-041 Accumulation with gap: len=4, four samples a=(1,0), b=(100,-50), SHIFT=0, with an idle cycle after sample 2 -> exactly one valid_o with (400,-200).
REQ-042 Saturation and rounding: SHIFT=15, OUT_WIDTH=16, len=2, a=b=(32767,0) -> pr=32767, sat_o=1. Separately, len=1, a=(16384,0), b=(1,0) -> pr=1 from rounding 0.5 up.
REQ-043 ce freeze: toggle ce low for 3 cycles mid-frame -> result identical to the ce-high run, with valid_o delayed by 3 cycles.
REQ-044 clr abort: clr pulsed after 2 of 4 samples, then 4 fresh samples -> a single valid_o with the sum of the fresh samples only.
REQ-045 Async reset: RST pulsed low mid-frame, asynchronous to CLK -> outputs 0 immediately, and the next full frame sums correctly.
